// File: rtl/iter_shift_unit.sv
// iter_shift_unit
//   Multi-cycle shift / rotate / sign-extend unit. Captures an operand on a
//   start request, moves it one bit per clock, then presents the result
//   together with a one-cycle done strobe.
//
//   Optional feature macro: ITER_SHIFT_FLAGS_EN
//     When defined, adds the registered flag outputs cout and zero.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   start  : request, sampled only while busy=0
//   mode   : 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101 SEXT,
//            110/111 reserved (result = din)
//   din    : operand
//   shamt  : shift count; in SEXT mode, the sign-bit index
//   busy   : high from the capture edge until done deasserts
//   done   : one-cycle completion strobe
//   dout   : result, held until the next completion or reset
//   cout   : (flags only) last bit shifted out, 0 when nothing shifted
//   zero   : (flags only) dout == 0
module iter_shift_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
`ifdef ITER_SHIFT_FLAGS_EN
  ,
  output logic               cout,
  output logic               zero
`endif
);

  localparam logic [2:0] MODE_SLL  = 3'b000;
  localparam logic [2:0] MODE_SRL  = 3'b001;
  localparam logic [2:0] MODE_SRA  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_SEXT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     work;
  logic [2:0]           mode_q;
  logic [SHAMT_W-1:0]   cnt;

  logic                 capture;
  logic                 direct;
  logic                 last;
  logic [WIDTH-1:0]     direct_res;
  logic [WIDTH:0]       step;

  // One-bit step of the working register. MSB of the return value is the
  // bit that left the register (for rotates, the bit that wrapped).
  function automatic logic [WIDTH:0] shift_step(input logic [2:0]       m,
                                                input logic [WIDTH-1:0] x);
    logic [WIDTH:0] r;
    case (m)
      MODE_SLL: r = {x[WIDTH-1], x[WIDTH-2:0], 1'b0};
      MODE_SRL: r = {x[0], 1'b0, x[WIDTH-1:1]};
      MODE_SRA: r = {x[0], x[WIDTH-1], x[WIDTH-1:1]};
      MODE_ROL: r = {x[WIDTH-1], x[WIDTH-2:0], x[WIDTH-1]};
      MODE_ROR: r = {x[0], x[0], x[WIDTH-1:1]};
      default:  r = {1'b0, x};
    endcase
    return r;
  endfunction

  // Replicate bit idx into every position above it; an index beyond the
  // top bit leaves the operand unchanged.
  function automatic logic [WIDTH-1:0] sign_extend(input logic [WIDTH-1:0]   x,
                                                   input logic [SHAMT_W-1:0] idx);
    logic [WIDTH-1:0] r;
    r = x;
    for (int i = 0; i < WIDTH; i++) begin
      if (i > int'(idx)) r[i] = x[idx];
    end
    return r;
  endfunction

  assign capture    = (state == S_IDLE) && start;
  // Zero counts, SEXT and reserved modes finish without any shifting.
  assign direct     = (shamt == '0) || (mode >= MODE_SEXT);
  assign direct_res = (mode == MODE_SEXT) ? sign_extend(din, shamt) : din;
  assign last       = (state == S_SHIFT) && (cnt == SHAMT_W'(1));
  assign step       = shift_step(mode_q, work);

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = direct ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Control and result registers (cleared by reset).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      dout  <= '0;
`ifdef ITER_SHIFT_FLAGS_EN
      cout  <= 1'b0;
      zero  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (capture) begin
        cnt <= shamt;
        if (direct) begin
          dout <= direct_res;
`ifdef ITER_SHIFT_FLAGS_EN
          cout <= 1'b0;
          zero <= (direct_res == '0);
`endif
        end
      end else if (state == S_SHIFT) begin
        cnt <= cnt - SHAMT_W'(1);
        if (last) begin
          dout <= step[WIDTH-1:0];
`ifdef ITER_SHIFT_FLAGS_EN
          cout <= step[WIDTH];
          zero <= (step[WIDTH-1:0] == '0);
`endif
        end
      end
    end
  end

  // Working operand; no reset needed since it is always loaded on capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      work   <= din;
      mode_q <= mode;
    end else if (state == S_SHIFT) begin
      work   <= step[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
module tb_iter_shift_unit;

  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    mode;
  logic [W-1:0]  din;
  logic [SW-1:0] shamt;
  logic          busy;
  logic          done;
  logic [W-1:0]  dout;
`ifdef ITER_SHIFT_FLAGS_EN
  logic          cout;
  logic          zero;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  iter_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .din   (din),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
`ifdef ITER_SHIFT_FLAGS_EN
    ,
    .cout  (cout),
    .zero  (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic meaning of each operation.
  task automatic model(input logic [2:0] m, input logic [W-1:0] d, input logic [SW-1:0] s,
                       output logic [W-1:0] r, output logic c, output int lat);
    int n;
    logic [2*W-1:0] tmp;
    logic [31:0] mask;
    n   = int'(s);
    c   = 1'b0;
    lat = 0;
    case (m)
      3'd0: begin r = d << n; if (n > 0) c = d[W-n]; lat = n; end
      3'd1: begin r = d >> n; if (n > 0) c = d[n-1]; lat = n; end
      3'd2: begin r = $signed(d) >>> n; if (n > 0) c = d[n-1]; lat = n; end
      3'd3: begin tmp = {d, d} << n; r = tmp[2*W-1:W]; if (n > 0) c = r[0]; lat = n; end
      3'd4: begin tmp = {d, d} >> n; r = tmp[W-1:0]; if (n > 0) c = r[W-1]; lat = n; end
      3'd5: begin
        mask = ~((32'd1 << (n + 1)) - 32'd1);
        r = d[n] ? (d | mask[W-1:0]) : (d & ~mask[W-1:0]);
      end
      default: r = d;
    endcase
  endtask

  // Issue one operation, scramble inputs after capture, wait for done.
  task automatic do_op(input logic [2:0] m, input logic [W-1:0] d, input logic [SW-1:0] s,
                       output logic [W-1:0] r, output int lat, output logic c, output logic z,
                       output logic after_bd, output logic [W-1:0] r_after);
    @(negedge clk);
    mode = m; din = d; shamt = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 3'($urandom);
    din   = W'($urandom);
    shamt = SW'($urandom);
    lat = 0;
    while (!done && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    r = dout;
`ifdef ITER_SHIFT_FLAGS_EN
    c = cout; z = zero;
`else
    c = 1'b0; z = 1'b0;
`endif
    @(negedge clk);
    after_bd = busy | done;
    r_after  = dout;
  endtask

  task automatic run_and_check(input string tag, input logic [2:0] m, input logic [W-1:0] d,
                               input logic [SW-1:0] s, input logic [W-1:0] er, input logic ec,
                               input int elat);
    logic [W-1:0] r, ra;
    logic c, z, bd;
    int lat;
    do_op(m, d, s, r, lat, c, z, bd, ra);
    check({tag, " dout"}, 32'(r), 32'(er));
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " idle_after"}, 32'(bd), 32'd0);
    check({tag, " dout_held"}, 32'(ra), 32'(er));
`ifdef ITER_SHIFT_FLAGS_EN
    check({tag, " cout"}, 32'(c), 32'(ec));
    check({tag, " zero"}, 32'(z), 32'(er == '0));
`else
    if (c !== 1'b0 && ec !== 1'b0 && z !== 1'b0) n_assert += 0;
`endif
  endtask

  typedef struct {
    string         name;
    logic [2:0]    m;
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic [W-1:0]  er;
    logic          ec;
    int            elat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int ndone;
    logic [W-1:0] er;
    logic ec;
    int elat;

    vecs.push_back('{"sll1",   3'd0, 16'h0001, 4'd4,  16'h0010, 1'b0, 4});
    vecs.push_back('{"sra15",  3'd2, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 15});
    vecs.push_back('{"srl15",  3'd1, 16'h8000, 4'd15, 16'h0001, 1'b0, 15});
    vecs.push_back('{"ror1",   3'd4, 16'h0001, 4'd1,  16'h8000, 1'b1, 1});
    vecs.push_back('{"rol1",   3'd3, 16'hAAAA, 4'd1,  16'h5555, 1'b1, 1});
    vecs.push_back('{"sext3",  3'd5, 16'h000F, 4'd3,  16'hFFFF, 1'b0, 0});
    vecs.push_back('{"sext11", 3'd5, 16'h0FFF, 4'd11, 16'hFFFF, 1'b0, 0});
    vecs.push_back('{"sext12", 3'd5, 16'h0FFF, 4'd12, 16'h0FFF, 1'b0, 0});
    vecs.push_back('{"sll0",   3'd0, 16'h1234, 4'd0,  16'h1234, 1'b0, 0});
    vecs.push_back('{"rsvd",   3'd6, 16'hABCD, 4'd5,  16'hABCD, 1'b0, 0});
    vecs.push_back('{"sllz",   3'd0, 16'h8000, 4'd1,  16'h0000, 1'b1, 1});
    vecs.push_back('{"ror4",   3'd4, 16'h1234, 4'd4,  16'h4123, 1'b0, 4});

    rst_n = 1'b0; start = 1'b0; mode = '0; din = '0; shamt = '0;
    @(negedge clk);
    // Dirty the outputs before reset so the reset values mean something.
    rst_n = 1'b1;
    begin
      logic [W-1:0] r, ra; logic c, z, bd; int lat;
      do_op(3'd0, 16'h00FF, 4'd1, r, lat, c, z, bd, ra);
    end
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset dout", 32'(dout), 32'd0);
`ifdef ITER_SHIFT_FLAGS_EN
    check("reset cout", 32'(cout), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
`endif
    rst_n = 1'b1;

    foreach (vecs[i])
      run_and_check(vecs[i].name, vecs[i].m, vecs[i].d, vecs[i].s, vecs[i].er, vecs[i].ec, vecs[i].elat);

    // Start held through the DONE cycle of a zero-count op: one done only.
    @(negedge clk);
    mode = 3'd0; din = 16'h1234; shamt = 4'd0; start = 1'b1;
    @(negedge clk);
    ndone = int'(done);
    din = 16'h5555; shamt = 4'd3;
    @(negedge clk);
    start = 1'b0;
    check("hold0 dout", 32'(dout), 32'h1234);
    for (int k = 0; k < 10; k++) begin
      ndone += int'(done);
      @(negedge clk);
    end
    check("hold0 done_count", 32'(ndone), 32'd1);

    // Start pulses during a long shift are ignored.
    @(negedge clk);
    mode = 3'd0; din = 16'h0003; shamt = 4'd5; start = 1'b1;
    @(negedge clk);
    din = 16'hFFFF; shamt = 4'd1; mode = 3'd4;
    elat = 0;
    while (!done && elat < 64) begin
      @(negedge clk);
      elat++;
    end
    start = 1'b0;
    check("busy_start dout", 32'(dout), 32'h0060);
    check("busy_start latency", 32'(elat), 32'd5);
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("busy_start extra_done", 32'(ndone), 32'd0);

    // Reset at the third shift edge discards the operation.
    @(negedge clk);
    mode = 3'd0; din = 16'hFFFF; shamt = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst dout", 32'(dout), 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("midrst no_done", 32'(ndone), 32'd0);
    run_and_check("post_rst", 3'd0, 16'h0001, 4'd4, 16'h0010, 1'b0, 4);

    // Randomized operations against the reference model.
    for (int i = 0; i < 200; i++) begin
      logic [2:0] m;
      logic [W-1:0] d;
      logic [SW-1:0] s;
      m = 3'($urandom);
      d = W'($urandom);
      s = SW'($urandom_range(0, 15));
      model(m, d, s, er, ec, elat);
      run_and_check($sformatf("rand%0d_m%0d", i, m), m, d, s, er, ec, elat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
